// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit common-anode seven-segment scan controller with double-buffered value
// Optional decimal-point support: define SEG_SCAN_DP_EN.
module seg_scan_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  output logic        busy,
  output logic        ack,
  output logic        frame_start,
`ifdef SEG_SCAN_DP_EN
  input  logic [3:0]  dp,
  output logic        dp_n,
`endif
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int MAXC = (PRESCALE > GUARD) ? PRESCALE : GUARD;
  localparam int TW   = $clog2(MAXC);

  typedef enum logic {S_GUARD = 1'b0, S_DRIVE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    idx_q, idx_d;
  logic          started_q, started_d;
  logic [15:0]   display_q, display_d;
  logic [15:0]   pending_q, pending_d;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;
  logic          fs_q, fs_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
`ifdef SEG_SCAN_DP_EN
  logic [3:0]    disp_dp_q, disp_dp_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          dp_n_q, dp_n_d;
`endif

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  // Digit i > 0 is a leading zero when it and every more significant nibble is zero.
  function automatic logic is_blank(input logic [15:0] v, input logic [1:0] i);
    case (i)
      2'd1:    is_blank = (v[15:4] == 12'h000);
      2'd2:    is_blank = (v[15:8] == 8'h00);
      2'd3:    is_blank = (v[15:12] == 4'h0);
      default: is_blank = 1'b0;
    endcase
  endfunction

  // Next-state, handshake/commit and registered-output computation.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    idx_d     = idx_q;
    started_d = started_q;
    display_d = display_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    fs_d      = 1'b0;
`ifdef SEG_SCAN_DP_EN
    disp_dp_d = disp_dp_q;
    pend_dp_d = pend_dp_q;
`endif

    case (state_q)
      S_DRIVE: begin
        if (timer_q == TW'(PRESCALE - 1)) begin
          state_d = S_GUARD;
          timer_d = '0;
        end
      end
      default: begin
        if (timer_q == TW'(GUARD - 1)) begin
          state_d   = S_DRIVE;
          timer_d   = '0;
          started_d = 1'b1;
          // The very first exit after reset lands on digit 0 without advancing.
          idx_d     = started_q ? idx_q + 2'd1 : idx_q;
          if (idx_d == 2'd0) begin
            fs_d = 1'b1;
            if (busy_q) begin
              display_d = pending_q;
              busy_d    = 1'b0;
              ack_d     = 1'b1;
`ifdef SEG_SCAN_DP_EN
              disp_dp_d = pend_dp_q;
`endif
            end
          end
        end
      end
    endcase

    // A load on the commit edge refills pending after the old value moved out.
    if (load) begin
      pending_d = value;
      busy_d    = 1'b1;
`ifdef SEG_SCAN_DP_EN
      pend_dp_d = dp;
`endif
    end

    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    if (state_d == S_DRIVE) begin
      an_d = ~(4'b0001 << idx_d);
      if (!((BLANK_LZ != 0) && is_blank(display_d, idx_d)))
        seg_d = decode(display_d[{idx_d, 2'b00} +: 4]);
    end
`ifdef SEG_SCAN_DP_EN
    dp_n_d = (state_d == S_DRIVE) ? ~disp_dp_d[idx_d] : 1'b1;
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_GUARD;
      timer_q   <= '0;
      idx_q     <= 2'd0;
      started_q <= 1'b0;
      display_q <= 16'h0000;
      pending_q <= 16'h0000;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      fs_q      <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
`ifdef SEG_SCAN_DP_EN
      disp_dp_q <= 4'b0000;
      pend_dp_q <= 4'b0000;
      dp_n_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      started_q <= started_d;
      display_q <= display_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      fs_q      <= fs_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
`ifdef SEG_SCAN_DP_EN
      disp_dp_q <= disp_dp_d;
      pend_dp_q <= pend_dp_d;
      dp_n_q    <= dp_n_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign ack         = ack_q;
  assign frame_start = fs_q;
  assign an          = an_q;
  assign seg         = seg_q;
`ifdef SEG_SCAN_DP_EN
  assign dp_n        = dp_n_q;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl (PRESCALE=4, GUARD=2, BLANK_LZ=1)
module tb_seg_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        busy;
  logic        ack;
  logic        frame_start;
  logic [3:0]  an;
  logic [6:0]  seg;
`ifdef SEG_SCAN_DP_EN
  logic [3:0]  dp;
  logic        dp_n;
`endif

  int checks = 0;
  int errors = 0;
  int n;
  int acks;
  int d;
  int p;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic [6:0] segs [4];

  seg_scan_ctrl #(.PRESCALE(4), .GUARD(2), .BLANK_LZ(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .value       (value),
    .load        (load),
    .busy        (busy),
    .ack         (ack),
    .frame_start (frame_start),
`ifdef SEG_SCAN_DP_EN
    .dp          (dp),
    .dp_n        (dp_n),
`endif
    .an          (an),
    .seg         (seg)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  // Advance until frame_start is seen or 40 cycles pass; returns cycles taken and acks seen on the way.
  task automatic wait_fs(output int cnt, output int nacks);
    cnt = 0;
    nacks = 0;
    while (frame_start !== 1'b1 && cnt < 40) begin
      step();
      cnt++;
      if (ack === 1'b1) nacks++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load  = 1'b0;
    value = 16'h0000;
`ifdef SEG_SCAN_DP_EN
    dp = 4'b0000;
`endif
    step();
    step();
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || busy !== 1'b0 || ack !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_state an=%b seg=%b busy=%b ack=%b fs=%b want an=1111 seg=1111111 busy=0 ack=0 fs=0",
               an, seg, busy, ack, frame_start);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    wait_fs(n, acks);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL idle_first_fs_latency got=%0d want=2", n);
    end
    segs[0] = 7'b1000000; segs[1] = 7'h7F; segs[2] = 7'h7F; segs[3] = 7'h7F;
    for (int c = 0; c < 24; c++) begin
      d = c / 6;
      p = c % 6;
      exp_an  = (p < 4) ? ~(4'b0001 << d) : 4'b1111;
      exp_seg = (p < 4) ? segs[d] : 7'h7F;
      checks++;
      if (an !== exp_an || seg !== exp_seg || frame_start !== (c == 0) || ack !== 1'b0) begin
        errors++;
        $display("FAIL idle_frame c=%0d an=%b seg=%b fs=%b ack=%b want an=%b seg=%b fs=%b ack=0",
                 c, an, seg, frame_start, ack, exp_an, exp_seg, (c == 0));
      end
      step();
    end
    checks++;
    if (frame_start !== 1'b1 || ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_frame_period fs=%b ack=%b want fs=1 ack=0", frame_start, ack);
    end
  endtask

  task automatic test_load();
    load  = 1'b1;
    value = 16'h12AF;
    step();
    load = 1'b0;
    checks++;
    if (busy !== 1'b1 || ack !== 1'b0) begin
      errors++;
      $display("FAIL load_busy busy=%b ack=%b want busy=1 ack=0", busy, ack);
    end
    wait_fs(n, acks);
    checks++;
    if (frame_start !== 1'b1 || ack !== 1'b1 || busy !== 1'b0 || acks != 1) begin
      errors++;
      $display("FAIL load_commit fs=%b ack=%b busy=%b acks=%0d want fs=1 ack=1 busy=0 acks=1",
               frame_start, ack, busy, acks);
    end
    segs[0] = 7'b0001110; segs[1] = 7'b0001000; segs[2] = 7'b0100100; segs[3] = 7'b1111001;
    for (int c = 0; c < 24; c++) begin
      d = c / 6;
      p = c % 6;
      exp_an  = (p < 4) ? ~(4'b0001 << d) : 4'b1111;
      exp_seg = (p < 4) ? segs[d] : 7'h7F;
      checks++;
      if (an !== exp_an || seg !== exp_seg || ack !== (c == 0)) begin
        errors++;
        $display("FAIL load_frame c=%0d an=%b seg=%b ack=%b want an=%b seg=%b ack=%b",
                 c, an, seg, ack, exp_an, exp_seg, (c == 0));
      end
      step();
    end
  endtask

  task automatic test_latest_wins();
    load  = 1'b1;
    value = 16'h0001;
    step();
    value = 16'h0042;
    step();
    load = 1'b0;
    wait_fs(n, acks);
    checks++;
    if (ack !== 1'b1 || busy !== 1'b0 || acks != 1) begin
      errors++;
      $display("FAIL latest_commit ack=%b busy=%b acks=%0d want ack=1 busy=0 acks=1", ack, busy, acks);
    end
    segs[0] = 7'b0100100; segs[1] = 7'b0011001; segs[2] = 7'h7F; segs[3] = 7'h7F;
    acks = 0;
    for (int c = 0; c < 24; c++) begin
      d = c / 6;
      p = c % 6;
      exp_an  = (p < 4) ? ~(4'b0001 << d) : 4'b1111;
      exp_seg = (p < 4) ? segs[d] : 7'h7F;
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL latest_frame c=%0d an=%b seg=%b want an=%b seg=%b", c, an, seg, exp_an, exp_seg);
      end
      step();
      if (ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL latest_extra_ack got=%0d want=0", acks);
    end
  endtask

  task automatic test_load_on_commit();
    load  = 1'b1;
    value = 16'h0003;
    step();
    load = 1'b0;
    for (int i = 0; i < 22; i++) step();
    load  = 1'b1;
    value = 16'h0007;
    step();
    load = 1'b0;
    checks++;
    if (frame_start !== 1'b1 || ack !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL collide_commit fs=%b ack=%b busy=%b want fs=1 ack=1 busy=1", frame_start, ack, busy);
    end
    segs[0] = 7'b0110000; segs[1] = 7'h7F; segs[2] = 7'h7F; segs[3] = 7'h7F;
    for (int c = 0; c < 24; c++) begin
      d = c / 6;
      p = c % 6;
      exp_an  = (p < 4) ? ~(4'b0001 << d) : 4'b1111;
      exp_seg = (p < 4) ? segs[d] : 7'h7F;
      checks++;
      if (an !== exp_an || seg !== exp_seg || ack !== (c == 0) || busy !== 1'b1) begin
        errors++;
        $display("FAIL collide_frame c=%0d an=%b seg=%b ack=%b busy=%b want an=%b seg=%b ack=%b busy=1",
                 c, an, seg, ack, busy, exp_an, exp_seg, (c == 0));
      end
      step();
    end
    checks++;
    if (frame_start !== 1'b1 || ack !== 1'b1 || busy !== 1'b0 || an !== 4'b1110 || seg !== 7'b1111000) begin
      errors++;
      $display("FAIL collide_second fs=%b ack=%b busy=%b an=%b seg=%b want fs=1 ack=1 busy=0 an=1110 seg=1111000",
               frame_start, ack, busy, an, seg);
    end
  endtask

  task automatic test_reset_mid();
    load  = 1'b1;
    value = 16'h0005;
    step();
    load = 1'b0;
    for (int i = 0; i < 11; i++) step();
    checks++;
    if (an !== 4'b1011 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre an=%b busy=%b want an=1011 busy=1", an, busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || busy !== 1'b0 || ack !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state an=%b seg=%b busy=%b ack=%b want an=1111 seg=1111111 busy=0 ack=0",
               an, seg, busy, ack);
    end
    wait_fs(n, acks);
    checks++;
    if (n != 2 || ack !== 1'b0 || acks != 0 || busy !== 1'b0 || an !== 4'b1110 || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL midreset_after n=%0d ack=%b acks=%0d busy=%b an=%b seg=%b want n=2 ack=0 acks=0 busy=0 an=1110 seg=1000000",
               n, ack, acks, busy, an, seg);
    end
  endtask

`ifdef SEG_SCAN_DP_EN
  task automatic test_dp();
    load  = 1'b1;
    value = 16'h0000;
    dp    = 4'b0100;
    step();
    load = 1'b0;
    step();
    wait_fs(n, acks);
    for (int c = 0; c < 24; c++) begin
      d = c / 6;
      p = c % 6;
      checks++;
      if (dp_n !== !((p < 4) && (d == 2))) begin
        errors++;
        $display("FAIL dp_frame c=%0d dp_n=%b want %b", c, dp_n, !((p < 4) && (d == 2)));
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_load();
    test_latest_wins();
    test_load_on_commit();
    test_reset_mid();
`ifdef SEG_SCAN_DP_EN
    test_dp();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
